// File: rtl/tile_cmd_issuer_if.sv
// tile_cmd_issuer_if
//   Bundles the job-descriptor port, the TPU command port and the status
//   outputs of tile_cmd_issuer.
//   master : the issuer (takes descriptors, drives commands, counts done_irq)
//   slave  : host + TPU control unit side (drives descriptors, cmd_ready,
//            done_irq, observes status)
//   Signals: job_valid/job_ready + job_* descriptor fields, cmd_valid/
//   cmd_ready/cmd_data, done_irq, job_done, outstanding, tiles_issued,
//   err_spurious.
interface tile_cmd_issuer_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  job_valid;
    logic                  job_ready;
    logic [7:0]            job_num_tiles;
    logic [ADDR_WIDTH-1:0] job_base_a;
    logic [ADDR_WIDTH-1:0] job_base_b;
    logic [ADDR_WIDTH-1:0] job_base_c;
    logic [ADDR_WIDTH-1:0] job_base_d;
    logic [ADDR_WIDTH-1:0] job_stride_a;
    logic [ADDR_WIDTH-1:0] job_stride_b;
    logic [ADDR_WIDTH-1:0] job_stride_c;
    logic [ADDR_WIDTH-1:0] job_stride_d;
    logic [7:0]            job_len_m;
    logic [7:0]            job_len_k;
    logic [7:0]            job_len_n;

    logic                  cmd_valid;
    logic [63:0]           cmd_data;
    logic                  cmd_ready;

    logic                  done_irq;
    logic                  job_done;
    logic [3:0]            outstanding;
    logic [7:0]            tiles_issued;
    logic                  err_spurious;

    modport master (
        input  job_valid, job_num_tiles,
        input  job_base_a, job_base_b, job_base_c, job_base_d,
        input  job_stride_a, job_stride_b, job_stride_c, job_stride_d,
        input  job_len_m, job_len_k, job_len_n,
        output job_ready,
        output cmd_valid, cmd_data,
        input  cmd_ready,
        input  done_irq,
        output job_done, outstanding, tiles_issued, err_spurious
    );

    modport slave (
        output job_valid, job_num_tiles,
        output job_base_a, job_base_b, job_base_c, job_base_d,
        output job_stride_a, job_stride_b, job_stride_c, job_stride_d,
        output job_len_m, job_len_k, job_len_n,
        input  job_ready,
        input  cmd_valid, cmd_data,
        output cmd_ready,
        output done_irq,
        input  job_done, outstanding, tiles_issued, err_spurious
    );
endinterface

// File: rtl/tile_cmd_issuer.sv
// tile_cmd_issuer
//   Host-side initiator for the TPU command port. Takes one job descriptor
//   (tile count, four base addresses, four strides, tile dimensions) and
//   emits one packed 64-bit command per tile with addresses base + i*stride
//   (mod 2^ADDR_WIDTH). Caps issued-but-not-completed tiles at
//   MAX_OUTSTANDING, counts completions on done_irq, and pulses job_done
//   once every tile of the job has completed.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     bus       : tile_cmd_issuer_if master modport (descriptor, command
//                 port, done_irq, status outputs)
//   cmd_data layout (LSB first): len_m[7:0], len_k[15:8], len_n[23:16],
//   then addr_a, addr_b, addr_c, addr_d (ADDR_WIDTH bits each); upper
//   unused bits are zero.
module tile_cmd_issuer #(
    parameter int ADDR_WIDTH      = 10,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    tile_cmd_issuer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    localparam logic [3:0] CAP = 4'(MAX_OUTSTANDING);

    state_t                state;
    state_t                state_nxt;

    logic [7:0]            num_tiles;
    logic [7:0]            len_m;
    logic [7:0]            len_k;
    logic [7:0]            len_n;
    logic [ADDR_WIDTH-1:0] acc_a;
    logic [ADDR_WIDTH-1:0] acc_b;
    logic [ADDR_WIDTH-1:0] acc_c;
    logic [ADDR_WIDTH-1:0] acc_d;
    logic [ADDR_WIDTH-1:0] stride_a;
    logic [ADDR_WIDTH-1:0] stride_b;
    logic [ADDR_WIDTH-1:0] stride_c;
    logic [ADDR_WIDTH-1:0] stride_d;

    logic [3:0]            outstanding_q;
    logic [7:0]            tiles_q;
    logic                  job_done_q;
    logic                  err_q;

    logic                  accept;
    logic                  cmd_valid_c;
    logic                  job_ready_c;
    logic                  handshake;
    logic                  last_tile;
    logic                  job_done_nxt;
    logic [63:0]           cmd_data_c;

    assign accept    = (state == IDLE) && bus.job_valid;
    assign handshake = cmd_valid_c && bus.cmd_ready;
    assign last_tile = (tiles_q == num_tiles - 8'd1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; job_done is computed here and registered below
    always_comb begin
        state_nxt    = state;
        job_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.job_valid) begin
                    if (bus.job_num_tiles == 8'd0) begin
                        job_done_nxt = 1'b1;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (handshake && last_tile) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_q == 4'd0) begin
                    state_nxt    = IDLE;
                    job_done_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from registers only. The cap cannot withdraw a pending
    // valid because outstanding only rises on a handshake.
    always_comb begin
        job_ready_c = (state == IDLE);
        cmd_valid_c = (state == ISSUE) && (outstanding_q < CAP);
    end

    always_comb begin
        cmd_data_c                                 = '0;
        cmd_data_c[7:0]                            = len_m;
        cmd_data_c[15:8]                           = len_k;
        cmd_data_c[23:16]                          = len_n;
        cmd_data_c[24 +: ADDR_WIDTH]               = acc_a;
        cmd_data_c[24 + ADDR_WIDTH +: ADDR_WIDTH]   = acc_b;
        cmd_data_c[24 + 2*ADDR_WIDTH +: ADDR_WIDTH] = acc_c;
        cmd_data_c[24 + 3*ADDR_WIDTH +: ADDR_WIDTH] = acc_d;
    end

    // Descriptor latch, address accumulators and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            num_tiles     <= '0;
            len_m         <= '0;
            len_k         <= '0;
            len_n         <= '0;
            acc_a         <= '0;
            acc_b         <= '0;
            acc_c         <= '0;
            acc_d         <= '0;
            stride_a      <= '0;
            stride_b      <= '0;
            stride_c      <= '0;
            stride_d      <= '0;
            tiles_q       <= '0;
            outstanding_q <= '0;
            job_done_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            job_done_q <= job_done_nxt;

            if (accept) begin
                num_tiles <= bus.job_num_tiles;
                len_m     <= bus.job_len_m;
                len_k     <= bus.job_len_k;
                len_n     <= bus.job_len_n;
                acc_a     <= bus.job_base_a;
                acc_b     <= bus.job_base_b;
                acc_c     <= bus.job_base_c;
                acc_d     <= bus.job_base_d;
                stride_a  <= bus.job_stride_a;
                stride_b  <= bus.job_stride_b;
                stride_c  <= bus.job_stride_c;
                stride_d  <= bus.job_stride_d;
                tiles_q   <= '0;
            end else if (handshake) begin
                tiles_q <= tiles_q + 8'd1;
                // Accumulators wrap modulo 2^ADDR_WIDTH by construction
                acc_a   <= acc_a + stride_a;
                acc_b   <= acc_b + stride_b;
                acc_c   <= acc_c + stride_c;
                acc_d   <= acc_d + stride_d;
            end

            // Issue and completion in the same cycle cancel out; a completion
            // with nothing outstanding saturates at zero and flags an error.
            case ({handshake, bus.done_irq})
                2'b10: outstanding_q <= outstanding_q + 4'd1;
                2'b01: begin
                    if (outstanding_q == 4'd0) begin
                        err_q <= 1'b1;
                    end else begin
                        outstanding_q <= outstanding_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.job_ready    = job_ready_c;
    assign bus.cmd_valid    = cmd_valid_c;
    assign bus.cmd_data     = cmd_data_c;
    assign bus.job_done     = job_done_q;
    assign bus.outstanding  = outstanding_q;
    assign bus.tiles_issued = tiles_q;
    assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_tile_cmd_issuer.sv
// tb_tile_cmd_issuer
//   Self-checking bench for tile_cmd_issuer. A job-level reference model
//   (tile counts, outstanding count, address = base + i*stride mod 2^W)
//   pushes expected commands into a scoreboard queue when a job is accepted;
//   a monitor on the opposite clock edge pops and compares on every command
//   handshake and compares the status outputs against the model each cycle.
module tb_tile_cmd_issuer;

    localparam int W  = 10;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst;

    tile_cmd_issuer_if #(.ADDR_WIDTH(W)) bus ();

    tile_cmd_issuer #(
        .ADDR_WIDTH     (W),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];

    // Reference model state
    bit m_active;
    bit m_done;
    bit m_err;
    int m_T;
    int m_issued;
    int m_out;
    bit mh;
    bit mf;

    int hs_total  = 0;
    int ready_prob;
    int done_prob;
    int force_req = 0;
    int force_ack = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input int lm, input int lk, input int ln,
                                         input int a, input int b, input int c, input int d);
        logic [63:0] r;
        r = 64'(lm) | (64'(lk) << 8) | (64'(ln) << 16) | (64'(a) << 24)
          | (64'(b) << (24 + W)) | (64'(c) << (24 + 2*W)) | (64'(d) << (24 + 3*W));
        return r;
    endfunction

    function automatic int addr_of(input int base, input int stride, input int i);
        return (base + i * stride) % (1 << W);
    endfunction

    // Reference model, advanced on each active edge
    initial begin
        m_active = 0; m_done = 0; m_err = 0; m_T = 0; m_issued = 0; m_out = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_active = 0; m_done = 0; m_err = 0; m_T = 0; m_issued = 0; m_out = 0;
                sb.delete();
            end else begin
                mh = m_active && (m_issued < m_T) && (m_out < MO) && (bus.cmd_ready == 1'b1);
                mf = m_active && (m_issued == m_T) && (m_out == 0);
                m_done = 0;
                if (mf) begin
                    m_active = 0;
                    m_done   = 1;
                end else if (!m_active && bus.job_valid) begin
                    m_issued = 0;
                    if (bus.job_num_tiles == 8'd0) begin
                        m_done = 1;
                    end else begin
                        m_active = 1;
                        m_T      = int'(bus.job_num_tiles);
                        for (int i = 0; i < m_T; i++) begin
                            sb.push_back(pack(int'(bus.job_len_m), int'(bus.job_len_k), int'(bus.job_len_n),
                                addr_of(int'(bus.job_base_a), int'(bus.job_stride_a), i),
                                addr_of(int'(bus.job_base_b), int'(bus.job_stride_b), i),
                                addr_of(int'(bus.job_base_c), int'(bus.job_stride_c), i),
                                addr_of(int'(bus.job_base_d), int'(bus.job_stride_d), i)));
                        end
                    end
                end
                if (mh) m_issued++;
                if (mh && !bus.done_irq) begin
                    m_out++;
                end else if (!mh && bus.done_irq) begin
                    if (m_out == 0) m_err = 1;
                    else m_out--;
                end
            end
        end
    end

    // Control-unit side: cmd_ready and done_irq
    initial begin
        bus.cmd_ready = 1'b0;
        bus.done_irq  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.cmd_ready = (int'($urandom_range(99)) < ready_prob);
            bus.done_irq  = (m_out > 0) && (int'($urandom_range(99)) < done_prob);
            if (force_ack < force_req) begin
                bus.done_irq = 1'b1;
                force_ack++;
            end
        end
    end

    // Monitor: status against the model every cycle, commands against the scoreboard
    initial begin
        bit          prev_stall;
        logic [63:0] prev_data;
        bit          exp_valid;
        prev_stall = 0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            exp_valid = m_active && (m_issued < m_T) && (m_out < MO);
            check("job_ready",    64'(bus.job_ready),    64'(!m_active));
            check("cmd_valid",    64'(bus.cmd_valid),    64'(exp_valid));
            check("job_done",     64'(bus.job_done),     64'(m_done));
            check("outstanding",  64'(bus.outstanding),  64'(m_out));
            check("tiles_issued", 64'(bus.tiles_issued), 64'(8'(m_issued)));
            check("err_spurious", 64'(bus.err_spurious), 64'(m_err));
            if (prev_stall && !rst) begin
                check("hold_valid", 64'(bus.cmd_valid), 64'd1);
                check("hold_data",  bus.cmd_data,       prev_data);
            end
            if (!rst && bus.cmd_valid && bus.cmd_ready) begin
                hs_total++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected: got 0x%0h expected no command at %0t", bus.cmd_data, $time);
                end else begin
                    check("cmd_data", bus.cmd_data, sb.pop_front());
                end
            end
            prev_stall = !rst && bus.cmd_valid && !bus.cmd_ready;
            prev_data  = bus.cmd_data;
        end
    end

    task automatic start_job(input int t,
                             input int ba, input int bb, input int bc, input int bd,
                             input int sa, input int sbs, input int sc, input int sd,
                             input int lm, input int lk, input int ln);
        int n;
        @(posedge clk);
        #1;
        bus.job_num_tiles = 8'(t);
        bus.job_base_a    = W'(ba);  bus.job_base_b   = W'(bb);
        bus.job_base_c    = W'(bc);  bus.job_base_d   = W'(bd);
        bus.job_stride_a  = W'(sa);  bus.job_stride_b = W'(sbs);
        bus.job_stride_c  = W'(sc);  bus.job_stride_d = W'(sd);
        bus.job_len_m     = 8'(lm);  bus.job_len_k    = 8'(lk);
        bus.job_len_n     = 8'(ln);
        bus.job_valid     = 1'b1;
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (bus.job_ready) break;
        end
        if (n == 500) begin
            checks++;
            errors++;
            $display("FAIL job_accept_timeout: got job_ready=0 expected 1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
        // Descriptor inputs are ignored once the job is latched
        bus.job_num_tiles = 8'($urandom);
        bus.job_base_a    = W'($urandom);
        bus.job_stride_d  = W'($urandom);
        bus.job_len_m     = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (bus.job_ready && !m_active) break;
        end
        if (n == 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got job_ready=%0d expected 1 within 3000 cycles", bus.job_ready);
        end
    endtask

    initial begin
        int hs0;
        rst = 1'b1;
        ready_prob = 100;
        done_prob  = 0;
        bus.job_valid = 1'b0;
        bus.job_num_tiles = '0;
        bus.job_base_a = '0; bus.job_base_b = '0; bus.job_base_c = '0; bus.job_base_d = '0;
        bus.job_stride_a = '0; bus.job_stride_b = '0; bus.job_stride_c = '0; bus.job_stride_d = '0;
        bus.job_len_m = '0; bus.job_len_k = '0; bus.job_len_n = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_data",  bus.cmd_data,            64'd0);
        check("reset_job_ready", 64'(bus.job_ready),      64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single tile, known packed value
        start_job(1, 'h010, 'h020, 'h030, 'h040, 0, 0, 0, 0, 16, 16, 16);
        @(negedge clk);
        check("t1_valid", 64'(bus.cmd_valid), 64'd1);
        check("t1_data",  bus.cmd_data,       64'h1003_0080_1010_1010);
        force_req++;
        wait_idle();

        // Three tiles with strides, back-to-back issue
        done_prob = 60;
        start_job(3, 'h010, 'h020, 'h030, 'h040, 'h10, 0, 'h10, 'h20, 16, 16, 16);
        wait_idle();

        // Outstanding cap with no completions
        done_prob = 0;
        hs0 = hs_total;
        start_job(6, 'h100, 'h200, 'h300, 'h000, 1, 2, 3, 4, 8, 4, 2);
        repeat (10) @(negedge clk);
        check("cap_handshakes", 64'(hs_total - hs0), 64'd4);
        for (int i = 0; i < 6; i++) begin
            force_req++;
            repeat (3) @(negedge clk);
        end
        wait_idle();
        check("cap_total", 64'(hs_total - hs0), 64'd6);

        // Stall with cmd_ready low
        done_prob  = 50;
        ready_prob = 0;
        start_job(3, 'h055, 'h0AA, 'h155, 'h2AA, 'h11, 'h22, 'h33, 'h44, 1, 2, 3);
        repeat (6) @(negedge clk);
        ready_prob = 100;
        wait_idle();

        // Zero-tile job, then a spurious completion in IDLE
        start_job(0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11);
        @(negedge clk);
        check("t0_done",  64'(bus.job_done),  64'd1);
        check("t0_valid", 64'(bus.cmd_valid), 64'd0);
        force_req++;
        repeat (3) @(negedge clk);
        check("spurious_err", 64'(bus.err_spurious), 64'd1);
        check("spurious_out", 64'(bus.outstanding),  64'd0);

        // Address wrap
        start_job(2, 0, 0, 0, 'h3F0, 0, 0, 0, 'h20, 1, 1, 1);
        wait_idle();

        // Reset while draining
        done_prob = 0;
        start_job(2, 'h0F0, 'h0E0, 'h0D0, 'h0C0, 1, 1, 1, 1, 7, 7, 7);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_data",    bus.cmd_data,            64'd0);
        check("rst_cmd_valid",   64'(bus.cmd_valid),      64'd0);
        check("rst_outstanding", 64'(bus.outstanding),    64'd0);
        check("rst_err",         64'(bus.err_spurious),   64'd0);
        check("rst_tiles",       64'(bus.tiles_issued),   64'd0);

        // Randomised jobs, mostly back to back
        for (int j = 0; j < 30; j++) begin
            ready_prob = int'($urandom_range(30, 100));
            done_prob  = int'($urandom_range(10, 90));
            if ($urandom_range(9) == 0) force_req++;
            start_job(($urandom_range(7) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(0, 10)),
                      int'($urandom_range(1023)), int'($urandom_range(1023)),
                      int'($urandom_range(1023)), int'($urandom_range(1023)),
                      int'($urandom_range(1023)), int'($urandom_range(1023)),
                      int'($urandom_range(1023)), int'($urandom_range(1023)),
                      int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)));
            if ($urandom_range(2) == 0) wait_idle();
        end
        done_prob = 50;
        wait_idle();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
